// File: rtl/reg_wb_arbiter.sv
// Two-port register-file writeback arbiter with a pending-write scoreboard and stall counter.
// Define WB_ROUND_ROBIN_EN for round-robin contention; otherwise port 0 has fixed priority.
module reg_wb_arbiter #(
    parameter int REG_FILE_BITS = 5,
    parameter int REG_SIZE      = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req0_valid,
    input  logic [REG_FILE_BITS-1:0]      req0_num,
    input  logic [REG_SIZE-1:0]           req0_data,
    output logic                          req0_ready,
    input  logic                          req1_valid,
    input  logic [REG_FILE_BITS-1:0]      req1_num,
    input  logic [REG_SIZE-1:0]           req1_data,
    output logic                          req1_ready,
    input  logic                          alloc_valid,
    input  logic [REG_FILE_BITS-1:0]      alloc_num,
    output logic                          rf_we,
    output logic [REG_FILE_BITS-1:0]      rf_write_num,
    output logic [REG_SIZE-1:0]           rf_write_data,
    output logic [(1<<REG_FILE_BITS)-1:0] busy,
    output logic [15:0]                   stall_cnt
);
    localparam int REG_FILE_SIZE = 1 << REG_FILE_BITS;

    logic                     rf_we_reg;
    logic [REG_FILE_BITS-1:0] rf_write_num_reg;
    logic [REG_SIZE-1:0]      rf_write_data_reg;
    logic [REG_FILE_SIZE-1:0] busy_reg, busy_next;
    logic [15:0]              stall_cnt_reg, stall_cnt_next;

    logic                     xfer_any;
    logic [REG_FILE_BITS-1:0] win_num;
    logic [REG_SIZE-1:0]      win_data;
    logic                     stall;

`ifdef WB_ROUND_ROBIN_EN
    // last_reg == 1 means port 1 won the most recent transfer.
    logic last_reg, last_next;

    always_comb begin
        req0_ready = req0_valid && (!req1_valid || last_reg);
        req1_ready = req1_valid && (!req0_valid || !last_reg);
        last_next  = last_reg;
        if (req0_ready)
            last_next = 1'b0;
        else if (req1_ready)
            last_next = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_reg <= 1'b1;
        else
            last_reg <= last_next;
    end
`else
    always_comb begin
        req0_ready = req0_valid;
        req1_ready = req1_valid && !req0_valid;
    end
`endif

    assign xfer_any = req0_ready || req1_ready;
    assign win_num  = req0_ready ? req0_num  : req1_num;
    assign win_data = req0_ready ? req0_data : req1_data;
    assign stall    = (req0_valid && !req0_ready) || (req1_valid && !req1_ready);

    // Register 0 is never tracked; an alloc on the same edge as a clear wins.
    assign busy_next[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < REG_FILE_SIZE; gi++) begin : g_busy
            assign busy_next[gi] =
                (alloc_valid && (alloc_num == REG_FILE_BITS'(gi))) ? 1'b1 :
                (xfer_any && (win_num == REG_FILE_BITS'(gi)))      ? 1'b0 :
                busy_reg[gi];
        end
    endgenerate

    assign stall_cnt_next = (stall && (stall_cnt_reg != 16'hFFFF)) ?
                            stall_cnt_reg + 16'd1 : stall_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_reg         <= 1'b0;
            rf_write_num_reg  <= '0;
            rf_write_data_reg <= '0;
            busy_reg          <= '0;
            stall_cnt_reg     <= '0;
        end else begin
            rf_we_reg     <= xfer_any && (win_num != '0);
            busy_reg      <= busy_next;
            stall_cnt_reg <= stall_cnt_next;
            if (xfer_any && (win_num != '0)) begin
                rf_write_num_reg  <= win_num;
                rf_write_data_reg <= win_data;
            end
        end
    end

    assign rf_we         = rf_we_reg;
    assign rf_write_num  = rf_write_num_reg;
    assign rf_write_data = rf_write_data_reg;
    assign busy          = busy_reg;
    assign stall_cnt     = stall_cnt_reg;

endmodule

// File: doc/reg_wb_arbiter.md
REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

Interface
REQ-001 SHALL have parameter REG_FILE_BITS, default 5, register index width; REG_FILE_SIZE = 1 << REG_FILE_BITS.
REQ-002 SHALL have parameter REG_SIZE, default 64, register data width.
REQ-003 SHALL have clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have req0_valid / req1_valid  input  1 each  writeback request valid (0 = ALU, 1 = MEM/MUL).
REQ-006 SHALL have req0_num / req1_num  input  REG_FILE_BITS each  destination register.
REQ-007 SHALL have req0_data / req1_data  input  REG_SIZE each  writeback value.
REQ-008 SHALL have req0_ready / req1_ready  output  1 each  grant, combinational.
REQ-009 SHALL have alloc_valid  input  1, and alloc_num  input  REG_FILE_BITS; issue marks destination pending.
REQ-010 SHALL have rf_we  output  1, rf_write_num  output  REG_FILE_BITS, rf_write_data  output  REG_SIZE; register-file write port, registered.
REQ-011 SHALL have busy  output  REG_FILE_SIZE  per-register pending-write scoreboard, registered.
REQ-012 SHALL have stall_cnt  output  16  saturating count of cycles in which a valid requester was not granted.

Function
REQ-013 SHALL complete a transfer on port i when reqi_valid && reqi_ready at posedge; requesters hold valid/num/data stable until the transfer.
REQ-014 SHALL assert at most one ready per cycle; a lone valid requester is granted in the same cycle.
REQ-015 SHALL hold ready low on a port whose valid is low.
REQ-016 SHALL, when both valid, grant per the arbitration policy (REQ-027/028).
REQ-017 SHALL, one cycle after a transfer with num != 0, drive rf_we=1 with that num/data; otherwise rf_we=0 that cycle. rf_write_num/rf_write_data hold their last values while rf_we=0.
REQ-018 SHALL accept a num == 0 transfer (ready asserted) but keep rf_we=0 and leave busy unchanged.
REQ-019 SHALL set busy[alloc_num] at the posedge sampling alloc_valid, for alloc_num != 0.
REQ-020 SHALL clear busy[n] at the posedge on which a transfer to n is accepted.
REQ-021 SHALL give set priority when alloc and transfer hit the same register at the same edge; busy[n] stays 1.
REQ-022 SHALL hold busy[0] at 0 permanently.
REQ-023 SHALL increment stall_cnt by 1 per cycle in which any reqi_valid && !reqi_ready; saturate at 16'hFFFF, no wrap.

Reset
REQ-024 SHALL, on rst_n low, asynchronously clear rf_we, rf_write_num, rf_write_data, busy and stall_cnt to 0, and set the round-robin pointer to "last granted = 1".
REQ-025 SHALL drop a transfer accepted at the edge coinciding with reset assertion; no write issues after reset release.
REQ-026 SHALL resume arbitration at the first posedge after rst_n deasserts.

Configuration
REQ-027 SHALL, with macro WB_ROUND_ROBIN_EN defined, grant on contention to the port not granted last; the pointer updates on every transfer.
REQ-028 SHALL, without WB_ROUND_ROBIN_EN, use fixed priority: port 0 always wins contention; no pointer state is compiled.

Verification
REQ-029 SHALL test: req0 only, num=5, data=64'hDEAD -> req0_ready=1 same cycle; next cycle rf_we=1, rf_write_num=5, rf_write_data=64'hDEAD.
REQ-030 SHALL test: both valid for 4 cycles (num 3/4) -> RR: grants 0,1,0,1 and stall_cnt=4; fixed: grants 0,0,0,0.
REQ-031 SHALL test: alloc 7, then transfer to 7 two cycles later -> busy[7]=1 then 0; alloc 7 coincident with transfer to 7 -> busy[7] stays 1.
REQ-032 SHALL test: transfer num=0 and alloc num=0 -> ready=1, rf_we stays 0, busy=0.
REQ-033 SHALL test: rst_n low mid-stream with busy=32'h0000_00F0, stall_cnt=9 -> all outputs 0 immediately, before the next clk edge.
REQ-034 SHALL test: req1 held valid behind req0 in fixed mode for 70000 cycles -> stall_cnt saturates at 16'hFFFF.
